bist_response_checker: RTL and testbench
========================================

# bist_response_checker

Built-in self-test sequencer and response checker that sits between a deterministic pattern generator and one SRAM port. It drives the generator's enable and reset and forwards each generated write or read operation to the SRAM. It keeps a latency-matched pipeline of expected read data, compares the returned data against it, and reports pass/fail, an error count and the first failing address.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM/pattern address width
- DATA_WIDTH, 32, SRAM word width
- MASK_WIDTH, 4, write-mask width
- READ_LATENCY, 1, cycles from the issuing edge to valid sram_dout (≥1)
- CNT_WIDTH, 16, error counter width

Ports:
- clk  in  1  single clock, rising edge
- rstb  in  1  asynchronous, active-low reset
- start  in  1  begins a test when in IDLE or DONE; ignored otherwise
- stop_on_fail  in  1  stops issuing operations after the first detected mismatch; sampled at start
- pg_rst  out  1  synchronous reset to the pattern generator
- pg_en  out  1  advance enable to the pattern generator
- pg_addr  in  ADDR_WIDTH  current operation address
- pg_we / pg_re  in  1  current operation is a write / read
- pg_data  in  DATA_WIDTH  write data
- pg_check  in  DATA_WIDTH  expected read data
- pg_wmask  in  MASK_WIDTH  write mask
- pg_done  in  1  generator has exhausted its pattern
- sram_ce, sram_we  out  1  SRAM chip enable / write enable
- sram_addr  out  ADDR_WIDTH
- sram_din  out  DATA_WIDTH
- sram_wmask  out  MASK_WIDTH
- sram_dout  in  DATA_WIDTH  SRAM read data
- busy  out  1  in RUN or DRAIN
- done  out  1  in DONE
- fail  out  1  at least one mismatch in the last or current test
- err_count  out  CNT_WIDTH  mismatching reads; saturates at all-ones
- first_fail_addr  out  ADDR_WIDTH  address of the first mismatch
- first_fail_bits  out  DATA_WIDTH  sram_dout XOR expected data at the first mismatch

## Operation
States and transitions:
- IDLE → RUN on start.
- RUN → DRAIN when pg_done=1, or when stop_on_fail is latched and a mismatch is detected.
- DRAIN → DONE when the pipeline is empty.
- DONE → RUN on start.

IDLE / DONE:
- pg_rst=1, pg_en=0, sram_ce=0.
- Status outputs hold their last values.

On start:
- Clear fail, err_count, first_fail_addr and first_fail_bits.
- Latch stop_on_fail.
- Enter RUN.

RUN:
- pg_rst=0. pg_en=!pg_done.
- Ops are forwarded combinationally: sram_ce=(pg_we|pg_re)&!pg_done, sram_we=pg_we, sram_addr=pg_addr, sram_din=pg_data, sram_wmask=pg_wmask.
- If pg_we and pg_re are both 1, a write is performed and no compare is scheduled.
- A compare is scheduled only for pure reads (pg_re=1, pg_we=0).

Compare pipeline:
- READ_LATENCY stages, each holding valid, expected data (pg_check) and address.
- Entries are loaded at the issuing edge and shift one stage per cycle in all states.
- At the last stage, valid=1 and sram_dout≠expected is a mismatch:
  - fail←1.
  - err_count increments unless it is all-ones.
  - If this is the first mismatch of the test, capture first_fail_addr and first_fail_bits.

DRAIN:
- pg_en=0, sram_ce=0. No new ops are issued.
- In-flight reads still compare and still count.

Reset (rstb=0):
- Immediately: IDLE, pipeline cleared, pg_rst=1, pg_en=0, sram_ce=0, sram_we=0.
- All status outputs and counters are 0; sram_addr, sram_din and sram_wmask are 0.
- Reset mid-test abandons the test with no status retained.

## Timing
- The first RUN cycle begins one cycle after start is sampled. The generator leaves reset at that same edge.
- An op presented in cycle t is sampled by the SRAM at the edge ending t. Its sram_dout is compared during cycle t+READ_LATENCY. The resulting status is visible in cycle t+READ_LATENCY+1.
- Stop on fail: the mismatch is registered at the end of cycle t+READ_LATENCY, and the state is DRAIN from cycle t+READ_LATENCY+1. Ops issued in between are completed and checked.
- DRAIN lasts exactly READ_LATENCY cycles. done rises the cycle after the last compare.
- pg_done=1 with a valid op in the same cycle: that op is not issued.
- A start while busy has no effect.

## Test plan
- Ideal SRAM model, READ_LATENCY=1, hand-driven ops:
  - Stimulus: write 0xA5 to address 3, then read address 3 expecting 0xA5, then pg_done.
  - Required: sram_ce pulses twice, sram_we=1 then 0; done=1, fail=0, err_count=0.
- Stuck-at fault (address 5, bit 3 stuck at 1), DATA_WIDTH=8:
  - Stimulus: write 0x00 to address 5, then read it expecting 0x00.
  - Required: fail=1, err_count=1, first_fail_addr=5, first_fail_bits=0x08.
- Three failing reads at addresses 2, 7, 9:
  - Stimulus: stop_on_fail=0.
  - Required: err_count=3, first_fail_addr=2. Also, with CNT_WIDTH=2 and five failing reads, err_count saturates at 3.
- READ_LATENCY=3, stop_on_fail=1, reads issued back-to-back, first mismatch on read #2:
  - Required: reads #3–#5 (already in flight) are still compared.
  - Required: no SRAM op after cycle t+3; done follows DRAIN by exactly 3 cycles.
- Reset mid-RUN:
  - Stimulus: rstb=0 asynchronously between edges.
  - Required: sram_ce and pg_en drop within the same cycle, pg_rst=1, all status=0.
- Restart from DONE:
  - Stimulus: after a failing run, pulse start.
  - Required: fail, err_count and first_fail are cleared the next cycle. A subsequent clean run ends with fail=0.
- Both pg_we and pg_re asserted on one op:
  - Required: a write is performed and no compare occurs.

Source files
------------

// File: rtl/bist_response_checker.sv
// rtl/bist_response_checker.sv - BIST sequencer that forwards pattern ops to one SRAM port and
// checks read data against a latency-matched pipeline of expected values.
module bist_response_checker #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  stop_on_fail,
  output logic                  pg_rst,
  output logic                  pg_en,
  input  logic [ADDR_WIDTH-1:0] pg_addr,
  input  logic                  pg_we,
  input  logic                  pg_re,
  input  logic [DATA_WIDTH-1:0] pg_data,
  input  logic [DATA_WIDTH-1:0] pg_check,
  input  logic [MASK_WIDTH-1:0] pg_wmask,
  input  logic                  pg_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_bits
);

  localparam int DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic                  r_sof;
  logic [DCW-1:0]        r_drain_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pg_rst;
  logic                  r_fail;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_ffa;
  logic [DATA_WIDTH-1:0] r_ffb;

  logic                  r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pa [READ_LATENCY];

  logic w_run;
  logic w_rd_issue;
  logic w_mismatch;
  logic w_err_sat;

  assign w_run      = (r_state == S_RUN);
  // A simultaneous write+read is treated as a write, so only pure reads enter the pipeline.
  assign w_rd_issue = w_run & pg_re & ~pg_we & ~pg_done;
  assign w_mismatch = r_pv[READ_LATENCY-1] && (sram_dout != r_pd[READ_LATENCY-1]);
  assign w_err_sat  = &r_err_count;

  assign pg_rst     = r_pg_rst;
  assign pg_en      = w_run & ~pg_done;
  assign sram_ce    = w_run & (pg_we | pg_re) & ~pg_done;
  assign sram_we    = w_run & pg_we;
  assign sram_addr  = w_run ? pg_addr  : '0;
  assign sram_din   = w_run ? pg_data  : '0;
  assign sram_wmask = w_run ? pg_wmask : '0;

  assign busy            = r_busy;
  assign done            = r_done;
  assign fail            = r_fail;
  assign err_count       = r_err_count;
  assign first_fail_addr = r_ffa;
  assign first_fail_bits = r_ffb;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_issue;
      r_pd[0] <= pg_check;
      r_pa[0] <= pg_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_sof       <= 1'b0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pg_rst    <= 1'b1;
      r_fail      <= 1'b0;
      r_err_count <= '0;
      r_ffa       <= '0;
      r_ffb       <= '0;
    end else begin
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (!w_err_sat) r_err_count <= r_err_count + CNT_WIDTH'(1);
        if (!r_fail) begin
          r_ffa <= r_pa[READ_LATENCY-1];
          r_ffb <= sram_dout ^ r_pd[READ_LATENCY-1];
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_sof       <= stop_on_fail;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pg_rst    <= 1'b0;
            r_fail      <= 1'b0;
            r_err_count <= '0;
            r_ffa       <= '0;
            r_ffb       <= '0;
          end
        end
        S_RUN: begin
          if (pg_done || (r_sof && w_mismatch)) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DCW'(READ_LATENCY - 1);
          end
        end
        S_DRAIN: begin
          // Every read still in flight was issued within the last READ_LATENCY RUN cycles.
          if (r_drain_cnt == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_pg_rst <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_response_checker.sv
// tb/tb_bist_response_checker.sv - bench driving a latency-1 and a latency-3 checker in
// lockstep, each against its own SRAM model with stuck-at faults.
module tb_bist_response_checker;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MW = 1;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic start = 1'b0;
  logic stop_on_fail = 1'b0;
  logic [AW-1:0] pg_addr = '0;
  logic pg_we = 1'b0, pg_re = 1'b0, pg_done = 1'b0;
  logic [DW-1:0] pg_data = '0, pg_check = '0;
  logic [MW-1:0] pg_wmask = '0;

  logic pg_rst_o [2], pg_en_o [2], ce_o [2], we_o [2], busy_o [2], done_o [2], fail_o [2];
  logic [AW-1:0] addr_o [2], ffa_o [2];
  logic [DW-1:0] din_o [2], dout_i [2], ffb_o [2];
  logic [MW-1:0] wm_o [2];
  logic [1:0] err_a;
  logic [15:0] err_b;
  logic [15:0] err_o [2];
  assign err_o[0] = {14'b0, err_a};
  assign err_o[1] = err_b;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bist_response_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                          .READ_LATENCY(1), .CNT_WIDTH(2)) u_dut_a (
    .clk(clk), .rstb(rstb), .start(start), .stop_on_fail(stop_on_fail),
    .pg_rst(pg_rst_o[0]), .pg_en(pg_en_o[0]), .pg_addr(pg_addr), .pg_we(pg_we), .pg_re(pg_re),
    .pg_data(pg_data), .pg_check(pg_check), .pg_wmask(pg_wmask), .pg_done(pg_done),
    .sram_ce(ce_o[0]), .sram_we(we_o[0]), .sram_addr(addr_o[0]), .sram_din(din_o[0]),
    .sram_wmask(wm_o[0]), .sram_dout(dout_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .fail(fail_o[0]), .err_count(err_a), .first_fail_addr(ffa_o[0]), .first_fail_bits(ffb_o[0]));

  bist_response_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                          .READ_LATENCY(3), .CNT_WIDTH(16)) u_dut_b (
    .clk(clk), .rstb(rstb), .start(start), .stop_on_fail(stop_on_fail),
    .pg_rst(pg_rst_o[1]), .pg_en(pg_en_o[1]), .pg_addr(pg_addr), .pg_we(pg_we), .pg_re(pg_re),
    .pg_data(pg_data), .pg_check(pg_check), .pg_wmask(pg_wmask), .pg_done(pg_done),
    .sram_ce(ce_o[1]), .sram_we(we_o[1]), .sram_addr(addr_o[1]), .sram_din(din_o[1]),
    .sram_wmask(wm_o[1]), .sram_dout(dout_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .fail(fail_o[1]), .err_count(err_b), .first_fail_addr(ffa_o[1]), .first_fail_bits(ffb_o[1]));

  // SRAM models: stuck-at-1 bits are ORed into every read of the faulty address.
  logic [DW-1:0] stuck [256];
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] rp_a;
  logic [DW-1:0] rp_b [3];
  logic mem_clr = 1'b1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (ce_o[0] && we_o[0] && wm_o[0][0]) mem_a[addr_o[0]] <= din_o[0];
      if (ce_o[1] && we_o[1] && wm_o[1][0]) mem_b[addr_o[1]] <= din_o[1];
    end
    rp_a    <= mem_a[addr_o[0]] | stuck[addr_o[0]];
    rp_b[0] <= mem_b[addr_o[1]] | stuck[addr_o[1]];
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end
  assign dout_i[0] = rp_a;
  assign dout_i[1] = rp_b[2];

  // Op list indexed by RUN cycle; the op at index n is presented together with pg_done.
  logic op_we [64], op_re [64], op_m [64];
  logic [AW-1:0] op_addr [64];
  logic [DW-1:0] op_data [64], op_chk [64];
  logic [DW-1:0] mdl_mem [2][256];
  logic [DW-1:0] gen_mem [256];
  bit iss [2][64];

  task automatic set_op(input int k, input logic we, input logic re, input logic [AW-1:0] a,
                        input logic [DW-1:0] dta, input logic [DW-1:0] chk, input logic m);
    op_we[k] = we; op_re[k] = re; op_addr[k] = a; op_data[k] = dta; op_chk[k] = chk; op_m[k] = m;
  endtask

  task automatic clear_ops();
    for (int k = 0; k < 64; k++) set_op(k, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic drive(input int k, input bit valid);
    if (valid) begin
      pg_we = op_we[k]; pg_re = op_re[k]; pg_addr = op_addr[k];
      pg_data = op_data[k]; pg_check = op_chk[k]; pg_wmask = op_m[k];
    end else begin
      pg_we = 1'b0; pg_re = 1'b0; pg_addr = '0; pg_data = '0; pg_check = '0; pg_wmask = '0;
    end
  endtask

  // Reference: walk the ops in issue order, apply writes to a memory image, count bad reads.
  task automatic model(input int d, input bit sof, input int n, output int e, output int ec,
                       output int fa, output int fb);
    int rl, first;
    logic [DW-1:0] act;
    rl = (d == 0) ? 1 : 3;
    first = -1; ec = 0; fa = 0; fb = 0;
    for (int k = 0; k < 64; k++) iss[d][k] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (sof && first >= 0 && k > first + rl) break;
      iss[d][k] = 1'b1;
      if (op_we[k]) begin
        if (op_m[k]) mdl_mem[d][op_addr[k]] = op_data[k];
      end else if (op_re[k]) begin
        act = mdl_mem[d][op_addr[k]] | stuck[op_addr[k]];
        if (act != op_chk[k]) begin
          ec++;
          if (first < 0) begin first = k; fa = int'(op_addr[k]); fb = int'(act ^ op_chk[k]); end
        end
      end
    end
    e = (sof && first >= 0 && first + rl < n) ? first + rl : n;
    if (d == 0 && ec > 3) ec = 3;
  endtask

  task automatic run_ops(input string name, input bit sof, input int n);
    int e [2], ec [2], fa [2], fb [2];
    int kmax, rl;
    logic exp_ce;
    model(0, sof, n, e[0], ec[0], fa[0], fb[0]);
    model(1, sof, n, e[1], ec[1], fa[1], fb[1]);
    kmax = ((e[0] + 2 > e[1] + 4) ? e[0] + 2 : e[1] + 4) + 1;
    @(negedge clk);
    start = 1'b1; stop_on_fail = sof; pg_done = 1'b0; drive(0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; stop_on_fail = 1'($urandom_range(0, 1));
    for (int k = 0; k <= kmax; k++) begin
      drive(k, k <= n);
      pg_done = (k >= n);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rl = (d == 0) ? 1 : 3;
        exp_ce = iss[d][k] && (op_we[k] || op_re[k]);
        vecs++;
        if (ce_o[d] !== exp_ce) begin
          miscompares++;
          $display("FAIL %s sram_ce dut%0d cyc%0d got %b want %b", name, d, k, ce_o[d], exp_ce);
        end
        if (exp_ce) begin
          vecs++;
          if ({we_o[d], addr_o[d], din_o[d], wm_o[d]} !== {op_we[k], op_addr[k], op_data[k], op_m[k]}) begin
            miscompares++;
            $display("FAIL %s sram_op dut%0d cyc%0d got we=%b a=%h d=%h m=%b want we=%b a=%h d=%h m=%b",
                     name, d, k, we_o[d], addr_o[d], din_o[d], wm_o[d], op_we[k], op_addr[k], op_data[k], op_m[k]);
          end
        end
        vecs++;
        if (pg_en_o[d] !== (k <= e[d] && k < n)) begin
          miscompares++;
          $display("FAIL %s pg_en dut%0d cyc%0d got %b want %b", name, d, k, pg_en_o[d], (k <= e[d] && k < n));
        end
        vecs++;
        if (busy_o[d] !== (k <= e[d] + rl) || done_o[d] !== (k > e[d] + rl)) begin
          miscompares++;
          $display("FAIL %s busy_done dut%0d cyc%0d got %b%b want %b%b", name, d, k,
                   busy_o[d], done_o[d], (k <= e[d] + rl), (k > e[d] + rl));
        end
        if (k <= e[d] || k > e[d] + rl) begin
          vecs++;
          if (pg_rst_o[d] !== (k > e[d] + rl)) begin
            miscompares++;
            $display("FAIL %s pg_rst dut%0d cyc%0d got %b want %b", name, d, k, pg_rst_o[d], (k > e[d] + rl));
          end
        end
        if (k == 0) begin
          vecs++;
          if (fail_o[d] !== 1'b0 || err_o[d] !== 16'd0 || ffa_o[d] !== '0 || ffb_o[d] !== '0) begin
            miscompares++;
            $display("FAIL %s status_clear dut%0d got f=%b e=%0d a=%h b=%h want all 0", name, d,
                     fail_o[d], err_o[d], ffa_o[d], ffb_o[d]);
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (fail_o[d] !== (ec[d] > 0) || err_o[d] !== 16'(ec[d]) || ffa_o[d] !== AW'(fa[d]) || ffb_o[d] !== DW'(fb[d])) begin
        miscompares++;
        $display("FAIL %s status dut%0d got f=%b e=%0d a=%h b=%h want f=%b e=%0d a=%h b=%h", name, d,
                 fail_o[d], err_o[d], ffa_o[d], ffb_o[d], (ec[d] > 0), ec[d], AW'(fa[d]), DW'(fb[d]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (pg_rst_o[d] !== 1'b1 || pg_en_o[d] !== 1'b0 || ce_o[d] !== 1'b0 || we_o[d] !== 1'b0 ||
          addr_o[d] !== '0 || din_o[d] !== '0 || wm_o[d] !== '0 || busy_o[d] !== 1'b0 ||
          done_o[d] !== 1'b0 || fail_o[d] !== 1'b0 || err_o[d] !== 16'd0 || ffa_o[d] !== '0 || ffb_o[d] !== '0) begin
        miscompares++;
        $display("FAIL %s dut%0d got rst=%b en=%b ce=%b we=%b a=%h d=%h m=%b bsy=%b dn=%b f=%b e=%0d fa=%h fb=%h want rst=1 rest 0",
                 name, d, pg_rst_o[d], pg_en_o[d], ce_o[d], we_o[d], addr_o[d], din_o[d], wm_o[d],
                 busy_o[d], done_o[d], fail_o[d], err_o[d], ffa_o[d], ffb_o[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      stuck[i] = '0; gen_mem[i] = '0; mdl_mem[0][i] = '0; mdl_mem[1][i] = '0;
    end
    pg_addr = 8'h5A; pg_we = 1'b1; pg_re = 1'b1; pg_data = 8'hC3; pg_wmask = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstb = 1'b1; mem_clr = 1'b0;
    drive(0, 1'b0);
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_write_read();
    clear_ops();
    set_op(0, 1'b1, 1'b0, 8'd3, 8'hA5, 8'h00, 1'b1);
    set_op(1, 1'b0, 1'b1, 8'd3, 8'h00, 8'hA5, 1'b0);
    set_op(2, 1'b1, 1'b0, 8'd3, 8'hFF, 8'h00, 1'b1);
    run_ops("write_read", 1'b0, 2);
  endtask

  task automatic test_stuck_at();
    clear_ops();
    stuck[5] = 8'h08;
    set_op(0, 1'b1, 1'b0, 8'd5, 8'h00, 8'h00, 1'b1);
    set_op(1, 1'b0, 1'b1, 8'd5, 8'h00, 8'h00, 1'b0);
    run_ops("stuck_at", 1'b0, 2);
  endtask

  task automatic test_multi_fail();
    logic [AW-1:0] rd [6];
    clear_ops();
    stuck[2] = 8'h01; stuck[7] = 8'h80; stuck[9] = 8'h10;
    set_op(0, 1'b1, 1'b0, 8'd2, 8'h00, 8'h00, 1'b1);
    set_op(1, 1'b1, 1'b0, 8'd7, 8'h00, 8'h00, 1'b1);
    set_op(2, 1'b1, 1'b0, 8'd9, 8'h00, 8'h00, 1'b1);
    set_op(3, 1'b1, 1'b0, 8'd4, 8'h00, 8'h00, 1'b1);
    set_op(4, 1'b0, 1'b1, 8'd2, 8'h00, 8'h00, 1'b0);
    set_op(5, 1'b0, 1'b1, 8'd4, 8'h00, 8'h00, 1'b0);
    set_op(6, 1'b0, 1'b1, 8'd7, 8'h00, 8'h00, 1'b0);
    set_op(7, 1'b0, 1'b1, 8'd9, 8'h00, 8'h00, 1'b0);
    run_ops("three_fails", 1'b0, 8);
    rd = '{8'd2, 8'd7, 8'd4, 8'd9, 8'd2, 8'd7};
    clear_ops();
    for (int k = 0; k < 6; k++) set_op(k, 1'b0, 1'b1, rd[k], 8'h00, 8'h00, 1'b0);
    run_ops("five_fails_saturate", 1'b0, 6);
  endtask

  task automatic test_stop_on_fail();
    clear_ops();
    stuck[11] = 8'h04; stuck[13] = 8'h02;
    for (int k = 0; k < 8; k++) set_op(k, 1'b0, 1'b1, AW'(10 + (k % 6)), 8'h00, 8'h00, 1'b0);
    run_ops("stop_on_fail", 1'b1, 8);
  endtask

  task automatic test_restart();
    clear_ops();
    set_op(0, 1'b0, 1'b1, 8'd10, 8'h00, 8'h00, 1'b0);
    set_op(1, 1'b0, 1'b1, 8'd12, 8'h00, 8'h00, 1'b0);
    run_ops("restart_clean", 1'b0, 2);
  endtask

  task automatic test_both_we_re();
    clear_ops();
    set_op(0, 1'b1, 1'b1, 8'd20, 8'h3C, 8'h00, 1'b1);
    set_op(1, 1'b0, 1'b1, 8'd20, 8'h00, 8'h3C, 1'b0);
    set_op(2, 1'b1, 1'b0, 8'd21, 8'h77, 8'h00, 1'b0);
    set_op(3, 1'b0, 1'b1, 8'd21, 8'h00, 8'h00, 1'b0);
    run_ops("we_and_re", 1'b0, 4);
  endtask

  task automatic test_reset_mid_run();
    clear_ops();
    stuck[50] = 8'h01;
    for (int k = 0; k < 24; k++) set_op(k, 1'b0, 1'b1, 8'd50, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    start = 1'b1; stop_on_fail = 1'b0; pg_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k, 1'b1);
      @(negedge clk);
      if (k == 4) begin
        for (int d = 0; d < 2; d++) begin
          vecs++;
          if (fail_o[d] !== 1'b1 || busy_o[d] !== 1'b1 || ce_o[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset dut%0d got f=%b bsy=%b ce=%b want 1 1 1", d, fail_o[d], busy_o[d], ce_o[d]);
          end
        end
      end
      @(posedge clk); #1;
    end
    drive(5, 1'b1);
    #2 rstb = 1'b0;
    #1 check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rstb = 1'b1;
    stuck[50] = '0;
  endtask

  task automatic test_random();
    int n, typ;
    logic [AW-1:0] a;
    logic [DW-1:0] dta, chk;
    logic m;
    for (int it = 0; it < 8; it++) begin
      clear_ops();
      for (int i = 0; i < 256; i++) stuck[i] = '0;
      stuck[32 + $urandom_range(0, 15)] = DW'(1 << $urandom_range(0, 7));
      n = $urandom_range(6, 20);
      for (int k = 0; k <= n; k++) begin
        typ = $urandom_range(0, 3);
        a = AW'(32 + $urandom_range(0, 15));
        dta = DW'($urandom);
        case (typ)
          0: begin
            m = ($urandom_range(0, 7) != 0);
            if (m && k < n) gen_mem[a] = dta;
            set_op(k, 1'b1, 1'b0, a, dta, DW'($urandom), m);
          end
          1: begin
            chk = gen_mem[a];
            if ($urandom_range(0, 9) == 0) chk = chk ^ 8'h40;
            set_op(k, 1'b0, 1'b1, a, dta, chk, 1'b0);
          end
          2: begin
            if (k < n) gen_mem[a] = dta;
            set_op(k, 1'b1, 1'b1, a, dta, DW'($urandom), 1'b1);
          end
          default: set_op(k, 1'b0, 1'b0, a, dta, DW'($urandom), 1'b1);
        endcase
      end
      run_ops("random", 1'($urandom_range(0, 1)), n);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stuck_at();
    test_multi_fail();
    test_stop_on_fail();
    test_restart();
    test_both_we_re();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
